// File: rtl/vec_cache_dataram_sched.sv
// vec_cache_dataram_sched
//   Two-grant round-robin scheduler in front of the vector cache data RAM.
//   Up to two requests are accepted per cycle, each to a different bank, and
//   every bank is held off for RAM_BUSY_CYC cycles after it is granted.
//   Accepted requests become RAM commands one cycle later. Reads additionally
//   produce a one-cycle rd_done pulse RD_LAT cycles after their command.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   sched_en_i     1 = new grants allowed; 0 = only drain in-flight work
//   req_vld_i      per-requester request valid (upper half reads, lower half writes)
//   req_bank_i     per-requester target bank, BANK_W bits per requester
//   req_rdy_o      combinational accept, one-hot per slot
//   ram_vld_o      registered command valid for slot 0 / slot 1
//   ram_wr_o       registered write flag per slot
//   ram_idx_o      registered granted requester index per slot
//   ram_bank_o     registered bank per slot
//   rd_done_o      per-requester read-data-available pulse
module vec_cache_dataram_sched #(
    parameter int REQ_NUM      = 10,
    parameter int BANK_NUM     = 4,
    parameter int BANK_W       = $clog2(BANK_NUM),
    parameter int IDX_W        = $clog2(REQ_NUM),
    parameter int RAM_BUSY_CYC = 2,
    parameter int RD_LAT       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_en_i,
    input  logic [REQ_NUM-1:0]         req_vld_i,
    input  logic [REQ_NUM*BANK_W-1:0]  req_bank_i,
    output logic [REQ_NUM-1:0]         req_rdy_o,
    output logic [1:0]                 ram_vld_o,
    output logic [1:0]                 ram_wr_o,
    output logic [2*IDX_W-1:0]         ram_idx_o,
    output logic [2*BANK_W-1:0]        ram_bank_o,
    output logic [REQ_NUM-1:0]         rd_done_o
);

    localparam int                CNT_W     = $clog2(RAM_BUSY_CYC + 1);
    localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(RAM_BUSY_CYC - 1);
    localparam logic [IDX_W:0]    REQ_LIM   = (IDX_W + 1)'(REQ_NUM);
    localparam logic [IDX_W-1:0]  WR_LIM    = IDX_W'(REQ_NUM / 2);

    logic [BANK_W-1:0]  reqBank   [REQ_NUM];
    logic [REQ_NUM-1:0] eligible;

    logic [CNT_W-1:0]   busyCnt_q [BANK_NUM];
    logic [CNT_W-1:0]   busyCnt_d [BANK_NUM];
    logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;

    logic               g0Vld, g1Vld;
    logic [IDX_W-1:0]   g0Idx, g1Idx;
    logic [BANK_W-1:0]  g0Bank, g1Bank;

    logic [1:0]         ramVld_q, ramVld_d;
    logic [1:0]         ramWr_q, ramWr_d;
    logic [2*IDX_W-1:0] ramIdx_q, ramIdx_d;
    logic [2*BANK_W-1:0] ramBank_q, ramBank_d;

    logic [RD_LAT-1:0]  pipeVld_q [2];
    logic [IDX_W-1:0]   pipeIdx_q [2][RD_LAT];

    // Index arithmetic modulo REQ_NUM; inputs never exceed 2*REQ_NUM-1.
    function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W:0] v);
        logic [IDX_W:0] r;
        r = (v >= REQ_LIM) ? v - REQ_LIM : v;
        return r[IDX_W-1:0];
    endfunction

    // Eligibility is also masked by rst so nothing is offered while the
    // scheduler is being cleared.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            reqBank[i]  = req_bank_i[i*BANK_W +: BANK_W];
            eligible[i] = req_vld_i[i] & sched_en_i & ~rst &
                          (busyCnt_q[reqBank[i]] == '0);
        end
    end

    // Slot 0 scans from rrPtr; slot 1 continues after slot 0 and rejects
    // the slot 0 bank so the two grants always hit different banks.
    always_comb begin
        logic [IDX_W-1:0] cidx;
        cidx   = '0;
        g0Vld  = 1'b0;
        g0Idx  = '0;
        g0Bank = '0;
        g1Vld  = 1'b0;
        g1Idx  = '0;
        g1Bank = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            cidx = wrapIdx({1'b0, rrPtr_q} + (IDX_W + 1)'(k));
            if (!g0Vld && eligible[cidx]) begin
                g0Vld  = 1'b1;
                g0Idx  = cidx;
                g0Bank = reqBank[cidx];
            end
        end
        if (g0Vld) begin
            for (int k = 1; k < REQ_NUM; k++) begin
                cidx = wrapIdx({1'b0, g0Idx} + (IDX_W + 1)'(k));
                if (!g1Vld && eligible[cidx] && (reqBank[cidx] != g0Bank)) begin
                    g1Vld  = 1'b1;
                    g1Idx  = cidx;
                    g1Bank = reqBank[cidx];
                end
            end
        end
    end

    always_comb begin
        req_rdy_o = '0;
        if (g0Vld) req_rdy_o[g0Idx] = 1'b1;
        if (g1Vld) req_rdy_o[g1Idx] = 1'b1;
    end

    // Next-state: pointer advances past the last grant, bank counters reload
    // on grant and otherwise count down, command registers mirror the grants.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (g1Vld)      rrPtr_d = wrapIdx({1'b0, g1Idx} + (IDX_W + 1)'(1));
        else if (g0Vld) rrPtr_d = wrapIdx({1'b0, g0Idx} + (IDX_W + 1)'(1));

        for (int b = 0; b < BANK_NUM; b++) begin
            busyCnt_d[b] = (busyCnt_q[b] != '0) ? busyCnt_q[b] - CNT_W'(1) : '0;
            if ((g0Vld && (g0Bank == BANK_W'(b))) || (g1Vld && (g1Bank == BANK_W'(b))))
                busyCnt_d[b] = BUSY_LOAD;
        end

        ramVld_d  = {g1Vld, g0Vld};
        ramWr_d   = {g1Vld & (g1Idx < WR_LIM), g0Vld & (g0Idx < WR_LIM)};
        ramIdx_d  = {g1Idx, g0Idx};
        ramBank_d = {g1Bank, g0Bank};
    end

    // State registers; the read pipes load from the registered command so a
    // read's tail lands RD_LAT cycles after its ram_vld cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr_q   <= '0;
            ramVld_q  <= '0;
            ramWr_q   <= '0;
            ramIdx_q  <= '0;
            ramBank_q <= '0;
            for (int b = 0; b < BANK_NUM; b++) busyCnt_q[b] <= '0;
            for (int s = 0; s < 2; s++) begin
                pipeVld_q[s] <= '0;
                for (int d = 0; d < RD_LAT; d++) pipeIdx_q[s][d] <= '0;
            end
        end else begin
            rrPtr_q   <= rrPtr_d;
            ramVld_q  <= ramVld_d;
            ramWr_q   <= ramWr_d;
            ramIdx_q  <= ramIdx_d;
            ramBank_q <= ramBank_d;
            for (int b = 0; b < BANK_NUM; b++) busyCnt_q[b] <= busyCnt_d[b];
            for (int s = 0; s < 2; s++) begin
                pipeVld_q[s][0] <= ramVld_q[s] & ~ramWr_q[s];
                pipeIdx_q[s][0] <= ramIdx_q[s*IDX_W +: IDX_W];
                for (int d = 1; d < RD_LAT; d++) begin
                    pipeVld_q[s][d] <= pipeVld_q[s][d-1];
                    pipeIdx_q[s][d] <= pipeIdx_q[s][d-1];
                end
            end
        end
    end

    // Both slot tails can fire together; they always carry distinct indices.
    always_comb begin
        rd_done_o = '0;
        for (int s = 0; s < 2; s++) begin
            if (pipeVld_q[s][RD_LAT-1]) rd_done_o[pipeIdx_q[s][RD_LAT-1]] = 1'b1;
        end
    end

    assign ram_vld_o  = ramVld_q;
    assign ram_wr_o   = ramWr_q;
    assign ram_idx_o  = ramIdx_q;
    assign ram_bank_o = ramBank_q;

endmodule

// File: tb/tb_vec_cache_dataram_sched.sv
// tb_vec_cache_dataram_sched
//   Directed bench for vec_cache_dataram_sched. The main instance uses the
//   default parameters; a second instance with RAM_BUSY_CYC=1 is used for the
//   round-robin fairness sequence where every requester stays asserted.
module tb_vec_cache_dataram_sched;

    localparam int REQ_NUM = 10;
    localparam int BANK_W  = 2;
    localparam int IDX_W   = 4;
    localparam int RD_LAT  = 2;

    typedef struct {
        int cyc;
        int wr;
        int idx;
        int bank;
    } cmdT;

    typedef struct {
        int cyc;
        int vec;
    } rdT;

    logic                      clk;
    logic                      rst;
    logic                      schedEn;
    logic [REQ_NUM-1:0]        reqVld;
    logic [REQ_NUM*BANK_W-1:0] reqBank;
    logic [REQ_NUM-1:0]        reqRdy;
    logic [1:0]                ramVld;
    logic [1:0]                ramWr;
    logic [2*IDX_W-1:0]        ramIdx;
    logic [2*BANK_W-1:0]       ramBank;
    logic [REQ_NUM-1:0]        rdDone;

    logic                      fEn;
    logic [REQ_NUM-1:0]        fReqVld;
    logic [REQ_NUM*BANK_W-1:0] fReqBank;
    logic [REQ_NUM-1:0]        fReqRdy;
    logic [1:0]                fRamVld;
    logic [1:0]                fRamWr;
    logic [2*IDX_W-1:0]        fRamIdx;
    logic [2*BANK_W-1:0]       fRamBank;
    logic [REQ_NUM-1:0]        fRdDone;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    cmdT expQ0[$];
    cmdT expQ1[$];
    rdT  rdQ[$];

    int fairLo [6] = '{0, 2, 4, 6, 8, 0};
    int fairHi [6] = '{1, 3, 5, 7, 9, 1};

    vec_cache_dataram_sched dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en_i (schedEn),
        .req_vld_i  (reqVld),
        .req_bank_i (reqBank),
        .req_rdy_o  (reqRdy),
        .ram_vld_o  (ramVld),
        .ram_wr_o   (ramWr),
        .ram_idx_o  (ramIdx),
        .ram_bank_o (ramBank),
        .rd_done_o  (rdDone)
    );

    vec_cache_dataram_sched #(.RAM_BUSY_CYC(1)) dutFair (
        .clk        (clk),
        .rst        (rst),
        .sched_en_i (fEn),
        .req_vld_i  (fReqVld),
        .req_bank_i (fReqBank),
        .req_rdy_o  (fReqRdy),
        .ram_vld_o  (fRamVld),
        .ram_wr_o   (fRamWr),
        .ram_idx_o  (fRamIdx),
        .ram_bank_o (fRamBank),
        .rd_done_o  (fRdDone)
    );

    // Free-running clock and a cycle counter used to timestamp expectations.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en);
        schedEn = en;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input int b);
        reqVld[i] = 1'b1;
        reqBank[i*BANK_W +: BANK_W] = 2'(b);
    endtask

    task automatic dropReq(input int i);
        reqVld[i] = 1'b0;
        reqBank[i*BANK_W +: BANK_W] = '0;
    endtask

    // A handshake in the current cycle shows up as a command next cycle.
    task automatic expCmd(input int s, input int idx, input int bank, input int wr);
        cmdT e;
        e.cyc  = cyc + 1;
        e.wr   = wr;
        e.idx  = idx;
        e.bank = bank;
        if (s == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    task automatic expRd(input int vec);
        rdT e;
        e.cyc = cyc + 1 + RD_LAT;
        e.vec = vec;
        rdQ.push_back(e);
    endtask

    // Per-slot monitor: every presented command must match the oldest
    // expectation; idle slots must be all-zero and must not leave an
    // expectation overdue.
    task automatic monitorSlot(input int s);
        cmdT e;
        bit  have;
        int  idx, bank, wr;
        idx  = int'(ramIdx[s*IDX_W +: IDX_W]);
        bank = int'(ramBank[s*BANK_W +: BANK_W]);
        wr   = int'(ramWr[s]);
        have = (s == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
        if (have) e = (s == 0) ? expQ0[0] : expQ1[0];
        if (ramVld[s]) begin
            if (!have) begin
                checkOutput($sformatf("unexpected_cmd_slot%0d_idx", s), idx, -1);
            end else begin
                if (s == 0) void'(expQ0.pop_front());
                else        void'(expQ1.pop_front());
                checkOutput($sformatf("cmd_slot%0d_cycle", s), cyc, e.cyc);
                checkOutput($sformatf("cmd_slot%0d_idx", s), idx, e.idx);
                checkOutput($sformatf("cmd_slot%0d_bank", s), bank, e.bank);
                checkOutput($sformatf("cmd_slot%0d_wr", s), wr, e.wr);
            end
        end else begin
            checkOutput($sformatf("idle_slot%0d_fields", s), idx + bank + wr, 0);
            if (have && e.cyc < cyc) begin
                checkOutput($sformatf("missing_cmd_slot%0d_idx", s), -1, e.idx);
                if (s == 0) void'(expQ0.pop_front());
                else        void'(expQ1.pop_front());
            end
        end
    endtask

    task automatic monitorRd();
        rdT e;
        if (rdDone != '0) begin
            if (rdQ.size() == 0) begin
                checkOutput("unexpected_rd_done", int'(rdDone), 0);
            end else begin
                e = rdQ.pop_front();
                checkOutput("rd_done_cycle", cyc, e.cyc);
                checkOutput("rd_done_vec", int'(rdDone), e.vec);
            end
        end else if (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin
            e = rdQ.pop_front();
            checkOutput("missing_rd_done", 0, e.vec);
        end
    endtask

    // Monitor samples on the falling edge, away from the registering edge.
    always @(negedge clk) begin
        if (!rst) begin
            monitorSlot(0);
            monitorSlot(1);
            monitorRd();
        end
    end

    initial begin
        logic [REQ_NUM-1:0] fairExp;
        rst      = 1'b1;
        schedEn  = 1'b1;
        reqVld   = '0;
        reqBank  = '0;
        fEn      = 1'b0;
        fReqVld  = '1;
        for (int i = 0; i < REQ_NUM; i++) fReqBank[i*BANK_W +: BANK_W] = 2'(i % 4);

        // Reset state, with a request pending to show req_rdy stays low.
        setReq(4, 0);
        #2;
        checkOutput("reset_req_rdy", int'(reqRdy), 0);
        checkOutput("reset_ram_vld", int'(ramVld), 0);
        checkOutput("reset_ram_wr", int'(ramWr), 0);
        checkOutput("reset_ram_idx", int'(ramIdx), 0);
        checkOutput("reset_ram_bank", int'(ramBank), 0);
        checkOutput("reset_rd_done", int'(rdDone), 0);
        repeat (2) step();
        dropReq(4);
        @(negedge clk);
        #1 rst = 1'b0;
        step();

        // Single write: requester 3 to bank 1.
        setReq(3, 1);
        applyStimulus(1'b1);
        checkOutput("single_wr_rdy", int'(reqRdy), 10'b0000001000);
        expCmd(0, 3, 1, 1);
        step();
        dropReq(3);
        applyStimulus(1'b1);
        checkOutput("single_wr_rdy_after", int'(reqRdy), 0);
        repeat (2) step();

        // Dual grant with a bank conflict: 0 and 2 now, 1 two cycles later.
        setReq(0, 2);
        setReq(1, 2);
        setReq(2, 3);
        applyStimulus(1'b1);
        checkOutput("dual_rdy", int'(reqRdy), 10'b0000000101);
        expCmd(0, 0, 2, 1);
        expCmd(1, 2, 3, 1);
        step();
        dropReq(0);
        dropReq(2);
        applyStimulus(1'b1);
        checkOutput("bank_busy_blocks", int'(reqRdy), 0);
        step();
        applyStimulus(1'b1);
        checkOutput("bank_free_regrant", int'(reqRdy), 10'b0000000010);
        expCmd(0, 1, 2, 1);
        step();
        dropReq(1);
        step();

        // Read 7 on bank 0; pointer is 2 here.
        setReq(7, 0);
        applyStimulus(1'b1);
        checkOutput("read7_rdy", int'(reqRdy), 10'b0010000000);
        expCmd(0, 7, 0, 0);
        expRd(10'b0010000000);
        step();
        dropReq(7);
        repeat (3) step();

        // Two reads together; pointer is 8 so 8 lands in slot 0.
        setReq(5, 1);
        setReq(8, 2);
        applyStimulus(1'b1);
        checkOutput("dual_read_rdy", int'(reqRdy), 10'b0100100000);
        expCmd(0, 8, 2, 0);
        expCmd(1, 5, 1, 0);
        expRd(10'b0100100000);
        step();
        dropReq(5);
        dropReq(8);
        repeat (3) step();

        // Fairness on the single-cycle-busy instance, all requesters held.
        for (int k = 0; k < 6; k++) begin
            fEn = 1'b1;
            #1;
            fairExp = '0;
            fairExp[fairLo[k]] = 1'b1;
            fairExp[fairHi[k]] = 1'b1;
            checkOutput($sformatf("fair_rdy_%0d", k), int'(fReqRdy), int'(fairExp));
            step();
            checkOutput($sformatf("fair_vld_%0d", k), int'(fRamVld), 3);
            checkOutput($sformatf("fair_idx_%0d", k), int'(fRamIdx), fairHi[k] * 16 + fairLo[k]);
        end
        fEn = 1'b0;

        // Gating: read 6 in flight, then four requests held with sched_en low.
        setReq(6, 3);
        applyStimulus(1'b1);
        checkOutput("gate_read6_rdy", int'(reqRdy), 10'b0001000000);
        expCmd(0, 6, 3, 0);
        expRd(10'b0001000000);
        step();
        dropReq(6);
        setReq(0, 0);
        setReq(1, 1);
        setReq(2, 2);
        setReq(9, 3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("gated_rdy_%0d", k), int'(reqRdy), 0);
            step();
        end
        applyStimulus(1'b1);
        checkOutput("ungate_rdy_a", int'(reqRdy), 10'b1000000001);
        expCmd(0, 9, 3, 0);
        expCmd(1, 0, 0, 1);
        expRd(10'b1000000000);
        step();
        dropReq(9);
        dropReq(0);
        applyStimulus(1'b1);
        checkOutput("ungate_rdy_b", int'(reqRdy), 10'b0000000110);
        expCmd(0, 1, 1, 1);
        expCmd(1, 2, 2, 1);
        step();
        dropReq(1);
        dropReq(2);
        repeat (3) step();

        // Async reset one cycle after a read grant; its rd_done must vanish.
        setReq(7, 0);
        applyStimulus(1'b1);
        checkOutput("midreset_read7_rdy", int'(reqRdy), 10'b0010000000);
        expCmd(0, 7, 0, 0);
        step();
        dropReq(7);
        @(negedge clk);
        #1 rst = 1'b1;
        setReq(2, 1);
        setReq(8, 2);
        #1;
        checkOutput("midreset_ram_vld", int'(ramVld), 0);
        checkOutput("midreset_ram_idx", int'(ramIdx), 0);
        checkOutput("midreset_rd_done", int'(rdDone), 0);
        checkOutput("midreset_req_rdy", int'(reqRdy), 0);
        repeat (2) step();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("post_reset_rdy", int'(reqRdy), 10'b0100000100);
        expCmd(0, 2, 1, 1);
        expCmd(1, 8, 2, 0);
        expRd(10'b0100000000);
        step();
        dropReq(2);
        dropReq(8);
        repeat (5) step();

        checkOutput("expq0_drained", expQ0.size(), 0);
        checkOutput("expq1_drained", expQ1.size(), 0);
        checkOutput("rdq_drained", rdQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_cache_dataram_sched.md
# vec_cache_dataram_sched

Registered two-grant round-robin scheduler for the vector cache data RAM. It accepts read requests (W/E/S/N/EV) and write requests (W/E/S/N/LF), at most two per cycle, each to a different RAM bank, and enforces a per-bank occupancy window. It drives the data RAM command ports one cycle after acceptance and pulses a per-requester read-done RD_LAT cycles later. It sits between the MSHR request sources and the data RAM banks.

## Interface
- REQ_NUM, 10, requester count; [REQ_NUM-1:REQ_NUM/2] are reads, [REQ_NUM/2-1:0] are writes
- BANK_NUM, 4, data RAM banks; BANK_W = $clog2(BANK_NUM)
- IDX_W, $clog2(REQ_NUM), requester index width
- RAM_BUSY_CYC, 2, cycles a bank is occupied per access (>=1)
- RD_LAT, 2, RAM read latency in cycles (>=1)

- clk  in  1  clock; all state rises on posedge
- rst  in  1  asynchronous, active-high reset
- sched_en  in  1  1 = grants allowed; 0 = no new grants, in-flight work completes
- req_vld  in  REQ_NUM  request valid per requester
- req_bank  in  REQ_NUM*BANK_W  target bank; slice i is bits [i*BANK_W +: BANK_W]
- req_rdy  out  REQ_NUM  combinational accept; req_vld[i]&req_rdy[i] = handshake
- ram_vld  out  2  registered command valid, slot 0 and slot 1
- ram_wr  out  2  1 = write command (requester index < REQ_NUM/2)
- ram_idx  out  2*IDX_W  granted requester index per slot
- ram_bank  out  2*BANK_W  bank per slot
- rd_done  out  REQ_NUM  one-cycle pulse when read data for requester i is available

## Operation
- Eligible[i] = req_vld[i] & sched_en & (busy_cnt[req_bank[i]] == 0).
- Slot 0 grant: first eligible index scanning upward from rr_ptr with wrap at REQ_NUM.
- Slot 1 grant: next eligible index scanning upward from the slot 0 index +1 with wrap, skipping any request whose bank equals the slot 0 bank. At most one grant per requester.
- req_rdy = slot0_onehot | slot1_onehot.
- rr_ptr update on any grant: (last granted index + 1) mod REQ_NUM, where last = slot 1 if granted, else slot 0. No grant leaves rr_ptr unchanged.
- Bank occupancy: per-bank busy_cnt, width $clog2(RAM_BUSY_CYC+1). On grant to bank b, load RAM_BUSY_CYC-1; otherwise decrement while nonzero. With RAM_BUSY_CYC=1 a bank is never blocked.
- Read tracking: per-slot shift pipe of depth RD_LAT carrying {vld, idx}, loaded when the ram_vld slot is a read. At the pipe tail, rd_done[idx] is set for one cycle. Two reads in one cycle pulse two distinct rd_done bits.
- sched_en=0: req_rdy=0, busy counters keep decrementing, read pipes keep draining.
- Requesters hold req_vld and req_bank stable until handshake. req_rdy never asserts without req_vld.

## Timing
- Cycle T: handshake (req_rdy=1). T+1: ram_vld/ram_wr/ram_idx/ram_bank for that grant, held for exactly 1 cycle. T+1+RD_LAT: rd_done pulse for a read.
- Same-bank re-grant is possible no earlier than T+RAM_BUSY_CYC.
- Reset values: req_rdy=0, ram_vld=0, ram_wr=0, ram_idx=0, ram_bank=0, rd_done=0, rr_ptr=0, busy_cnt=0, read pipes empty.
- Reset mid-operation clears all state immediately, including pending rd_done. Lost returns are the requesters' responsibility.
- The unused slot has ram_vld=0 and ram_idx/ram_bank/ram_wr=0.
- Wrap: with rr_ptr=9, a scan order of 9,0,1,... is required.

## Test plan
- Single write: req_vld[3]=1, bank 1 at T -> req_rdy[3]=1 at T. At T+1: ram_vld=2'b01, ram_idx slot0=3, ram_wr[0]=1, ram_bank=1. No rd_done. rr_ptr=4.
- Dual grant with bank conflict: req 0 and 1 on bank 2, req 2 on bank 3, rr_ptr=0 -> grants 0 and 2 at T. Req 1 is granted at T+2 (RAM_BUSY_CYC=2), not at T+1.
- Read return: read req 7, bank 0 at T -> ram_vld slot0 at T+1 with ram_wr=0, rd_done[7] pulse at T+3 only (RD_LAT=2). Two simultaneous reads 5 and 8 -> both rd_done bits pulse in the same cycle.
- Round-robin fairness with wrap: all 10 requesting with banks i%4, continuously reasserted, RAM_BUSY_CYC=1 -> grant pairs (0,1),(2,3),(4,5),(6,7),(8,9),(0,1). Each requester is served once per 5 cycles.
- sched_en gating: sched_en=0 with 4 requests pending -> req_rdy=0 and ram_vld=0, while an earlier read still produces its rd_done. Raising sched_en -> grants resume from the held rr_ptr.
- Async reset mid-flight: assert rst one cycle after a read grant -> ram_vld, rd_done and req_rdy go 0 immediately. No rd_done appears after release. The first post-reset grant scans from index 0.
